communication_sender: RTL and testbench

- Serial transmitter that sends one 8-bit byte per request over a single-wire data line (sd).
- Also drives a bit-rate strobe (freq) and a receiver-enable flag (rec_en) so the partner receiver can frame and sample the byte.
- Sits between a local byte producer (send_data/send_en) and the link to the communication receiver. finish_send is the receiver's "frame consumed" acknowledge.

---
 rtl/comm_pkg.sv | 18 +
 rtl/comm_bit_timer.sv | 47 ++++
 rtl/communication_sender.sv | 110 +++++++++++
 tb/tb_communication_sender.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the communication sender/receiver pair.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_ACK
  } comm_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 2;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/comm_bit_timer.sv
// Per-bit cycle counter: flags the last cycle of each bit period and
// produces the registered bit-rate strobe (high in the first half of a bit).
module comm_bit_timer
  import comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic run_next,
  output logic bit_done,
  output logic freq
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freq_q, freq_d;

  assign bit_done = run && (cnt_q == LAST_CNT);
  assign freq     = freq_q;

  // Next count restarts at every bit boundary and rests at zero outside a frame;
  // the strobe level is derived from the count the next cycle will see.
  always_comb begin
    cnt_d = '0;
    if (run && !bit_done) begin
      cnt_d = cnt_q + 1'b1;
    end
    freq_d = run_next && (cnt_d < HALF_CNT);
  end

  // Counter and strobe registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      freq_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      freq_q <= freq_d;
    end
  end

endmodule

// File: rtl/communication_sender.sv
// Single-wire serial transmitter: start bit, LSB-first payload, stop bit,
// then waits for the receiver acknowledge before accepting the next byte.
module communication_sender
  import comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 send_en,
  input  logic                 finish_send,
  output logic                 sd,
  output logic                 freq,
  output logic                 rec_en
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  comm_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 sd_q, sd_d;
  logic                 rec_en_q, rec_en_d;
  logic                 in_frame;
  logic                 bit_done;

  assign in_frame = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  comm_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk1),
    .rst_n    (rst),
    .run      (in_frame),
    .run_next (rec_en_d),
    .bit_done (bit_done),
    .freq     (freq)
  );

  // Next-state, shift and line-level decode; outputs are computed from the
  // next state so the registered lines line up with the state they describe.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (send_en) begin
          shift_d = send_data;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (finish_send) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rec_en_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    if (state_d == START) begin
      sd_d = START_BIT;
    end else if (state_d == DATA) begin
      sd_d = shift_d[0];
    end else begin
      sd_d = STOP_BIT;
    end
  end

  // FSM, shift register and registered line outputs; reset aborts any frame.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      sd_q     <= 1'b1;
      rec_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      sd_q     <= sd_d;
      rec_en_q <= rec_en_d;
    end
  end

  assign sd     = sd_q;
  assign rec_en = rec_en_q;

endmodule

// File: tb/tb_communication_sender.sv
// Bench for communication_sender: a monitor rebuilds each frame from sd,
// checks strobe and bit stability, and compares it against a queue of
// expected frames pushed when the stimulus is issued.
module tb_communication_sender;

  localparam int CPB          = 2;
  localparam int FRAME_CYCLES = 10 * CPB;

  // Expected frames, index 0 = first bit on the wire (start bit).
  localparam logic [9:0] F_AE = 10'b1_1010_1110_0;
  localparam logic [9:0] F_55 = 10'b1_0101_0101_0;
  localparam logic [9:0] F_FF = 10'b1_1111_1111_0;
  localparam logic [9:0] F_3C = 10'b1_0011_1100_0;
  localparam logic [9:0] F_C3 = 10'b1_1100_0011_0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  logic       clk1;
  logic       rst;
  logic [7:0] send_data;
  logic       send_en;
  logic       finish_send;
  logic       sd;
  logic       freq;
  logic       rec_en;

  vec_t       vecs[7];
  logic [9:0] expQ[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int framesDone = 0;
  int framesStarted = 0;
  int lastStartCyc = 0;
  bit checkGaps = 0;

  communication_sender #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .send_data  (send_data),
    .send_en    (send_en),
    .finish_send(finish_send),
    .sd         (sd),
    .freq       (freq),
    .rec_en     (rec_en)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Cycle counter used to time the acknowledge-to-start latency.
  always @(posedge clk1) begin
    cyc <= cyc + 1;
  end

  // Monitor: samples on the falling clock edge, rebuilds frames while rec_en
  // is high, checks idle levels otherwise, and scores every completed frame.
  initial begin : monitor
    bit         inFrame;
    int         pos;
    int         lowRun;
    int         bitErr;
    int         freqErr;
    int         phase;
    logic       curBit;
    logic [9:0] capBits;
    logic [9:0] expFrame;
    inFrame = 0;
    pos = 0;
    lowRun = 0;
    bitErr = 0;
    freqErr = 0;
    curBit = 1'b0;
    capBits = '0;
    forever begin
      @(negedge clk1);
      if (rst !== 1'b1) begin
        inFrame = 0;
        pos = 0;
        lowRun = 0;
      end else if (rec_en === 1'b1) begin
        if (!inFrame) begin
          inFrame = 1;
          pos = 0;
          capBits = '0;
          bitErr = 0;
          freqErr = 0;
          framesStarted++;
          lastStartCyc = cyc;
          if (checkGaps) begin
            tests++;
            if (lowRun != 2) begin
              fails++;
              $display("[TB] FAIL frame_gap: got %0d idle cycles, expected 2", lowRun);
            end
          end
        end
        if (pos < FRAME_CYCLES) begin
          phase = pos % CPB;
          if (phase == 0) curBit = sd;
          else if (sd !== curBit) bitErr++;
          if (phase == CPB / 2) capBits[pos / CPB] = sd;
          if (freq !== (phase < CPB / 2)) freqErr++;
        end
        pos++;
      end else begin
        if (inFrame) begin
          inFrame = 0;
          framesDone++;
          tests++;
          if (pos != FRAME_CYCLES) begin
            fails++;
            $display("[TB] FAIL frame_length: got %0d rec_en cycles, expected %0d", pos, FRAME_CYCLES);
          end
          tests++;
          if (bitErr != 0) begin
            fails++;
            $display("[TB] FAIL bit_stability: got %0d unstable cycles, expected 0", bitErr);
          end
          tests++;
          if (freqErr != 0) begin
            fails++;
            $display("[TB] FAIL freq_pattern: got %0d wrong cycles, expected 0", freqErr);
          end
          tests++;
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_frame: got frame %b, expected none", capBits);
          end else begin
            expFrame = expQ.pop_front();
            if (capBits !== expFrame) begin
              fails++;
              $display("[TB] FAIL frame_bits: got %b, expected %b", capBits, expFrame);
            end
          end
          lowRun = 0;
        end
        lowRun++;
        tests++;
        if (sd !== 1'b1 || freq !== 1'b0) begin
          fails++;
          $display("[TB] FAIL idle_level: got sd=%b freq=%b, expected sd=1 freq=0", sd, freq);
        end
      end
    end
  end

  // Drive all inputs just after a falling edge.
  task automatic applyStimulus(input logic [7:0] data, input logic en, input logic ack);
    @(negedge clk1);
    #1;
    send_data   = data;
    send_en     = en;
    finish_send = ack;
  endtask

  task automatic checkOutput(input string name, input logic expSd, input logic expFreq,
                             input logic expRecEn);
    tests++;
    if ({sd, freq, rec_en} !== {expSd, expFreq, expRecEn}) begin
      fails++;
      $display("[TB] FAIL %s: got sd=%b freq=%b rec_en=%b, expected sd=%b freq=%b rec_en=%b",
               name, sd, freq, rec_en, expSd, expFreq, expRecEn);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expected);
    tests++;
    if (got != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
    end
  endtask

  task automatic waitRecEn(input string name, input int budget);
    int n = 0;
    while (rec_en !== 1'b1 && n < budget) begin
      @(negedge clk1);
      #1;
      n++;
    end
    tests++;
    if (rec_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s: got no frame start within %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic waitFrames(input string name, input int target, input int budget);
    int n = 0;
    while (framesDone < target && n < budget) begin
      @(negedge clk1);
      #1;
      n++;
    end
    tests++;
    if (framesDone < target) begin
      fails++;
      $display("[TB] FAIL %s: got %0d frames, expected %0d", name, framesDone, target);
    end
  endtask

  task automatic waitStarts(input string name, input int target, input int budget);
    int n = 0;
    while (framesStarted < target && n < budget) begin
      @(negedge clk1);
      #1;
      n++;
    end
    tests++;
    if (framesStarted < target) begin
      fails++;
      $display("[TB] FAIL %s: got %0d frame starts, expected %0d", name, framesStarted, target);
    end
  endtask

  // Send exactly one byte: request, drop the request once the frame is on the wire.
  task automatic sendOne(input logic [7:0] data, input logic [9:0] frame);
    int target;
    expQ.push_back(frame);
    target = framesDone + 1;
    applyStimulus(data, 1'b1, 1'b1);
    waitRecEn("single_start", 50);
    applyStimulus(data, 1'b0, 1'b1);
    waitFrames("single_done", target, 200);
  endtask

  // Main test sequence.
  initial begin : stim
    int target;
    int ackCyc;
    int doneBefore;
    int startBase;

    vecs[0] = '{8'hAE, F_AE};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, F_FF};
    vecs[3] = '{8'h01, 10'b1_0000_0001_0};
    vecs[4] = '{8'h80, 10'b1_1000_0000_0};
    vecs[5] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[6] = '{8'h55, F_55};

    rst = 1'b1;
    send_en = 1'b0;
    finish_send = 1'b0;
    send_data = 8'h00;
    #1 rst = 1'b0;

    // Reset held, then a long idle stretch with no request.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      #1;
      checkOutput("reset_hold", 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    repeat (50) begin
      @(negedge clk1);
      #1;
    end
    checkOutput("idle_after_reset", 1'b1, 1'b0, 1'b0);
    checkCount("no_frame_while_idle", framesStarted, 0);

    // Table of single frames.
    finish_send = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sendOne(vecs[i].data, vecs[i].frame);
    end

    // Acknowledge held low: line idles, next frame starts two cycles after ack.
    expQ.push_back(F_AE);
    expQ.push_back(F_AE);
    target = framesDone + 1;
    applyStimulus(8'hAE, 1'b1, 1'b0);
    waitFrames("ack_first_frame", target, 200);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk1);
      #1;
      checkOutput("ack_hold", 1'b1, 1'b0, 1'b0);
    end
    finish_send = 1'b1;
    ackCyc = cyc;
    waitRecEn("ack_release", 50);
    checkCount("ack_to_start", lastStartCyc - ackCyc, 2);
    applyStimulus(8'hAE, 1'b0, 1'b1);
    waitFrames("ack_second_frame", target + 1, 200);

    // send_data changed mid-frame only affects the following frame.
    expQ.push_back(F_AE);
    expQ.push_back(F_55);
    target = framesDone + 2;
    applyStimulus(8'hAE, 1'b1, 1'b1);
    waitRecEn("stab_start", 50);
    repeat (5) @(negedge clk1);
    applyStimulus(8'h55, 1'b1, 1'b1);
    waitFrames("stab_first", target - 1, 200);
    waitRecEn("stab_second_start", 50);
    applyStimulus(8'h55, 1'b0, 1'b1);
    waitFrames("stab_second", target, 200);

    // Reset asserted in the middle of the payload.
    doneBefore = framesDone;
    applyStimulus(8'h3C, 1'b1, 1'b1);
    waitRecEn("abort_start", 50);
    repeat (6) @(negedge clk1);
    #1;
    rst = 1'b0;
    send_en = 1'b0;
    #1;
    checkOutput("async_reset", 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk1);
    #1;
    checkOutput("reset_held_mid", 1'b1, 1'b0, 1'b0);
    @(negedge clk1);
    #1;
    rst = 1'b1;
    checkCount("abort_not_counted", framesDone, doneBefore);
    sendOne(8'hC3, F_C3);
    if (F_3C == F_C3) $display("[TB] note: frame constants overlap");

    // Continuous send of five 0xFF frames with two-cycle gaps.
    for (int i = 0; i < 5; i++) expQ.push_back(F_FF);
    target = framesDone + 5;
    startBase = framesStarted;
    applyStimulus(8'hFF, 1'b1, 1'b1);
    waitRecEn("cont_start", 50);
    checkGaps = 1;
    waitStarts("cont_starts", startBase + 5, 500);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    waitFrames("cont_done", target, 200);
    checkGaps = 0;

    repeat (10) @(negedge clk1);
    checkCount("queue_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
